// File: rtl/ps2_scancode_processor.sv
// PS/2 set-2 byte stream to key events: resolves E0/F0 prefixes, collapses Pause, tracks shift/caps-lock.
// Event written 1 cycle after the done rise into a FWFT FIFO; when it is full and not popping, events are dropped and overflow pulses.
module ps2_scancode_processor #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] code,
  input  logic       done,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_extended,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow,
  output logic       proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_PAUSE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  skip_cnt_q, skip_cnt_d;
  logic        done_d_q;
  logic        strobe, is_prefix, is_filtered;
  logic        emit, emit_brk, emit_ext, perr;
  logic [7:0]  emit_code;

  assign strobe      = done & ~done_d_q;
  assign is_prefix   = (code == 8'hE0) || (code == 8'hF0) || (code == 8'hE1);
  assign is_filtered = (code == 8'h00) || (code == 8'hAA) || (code == 8'hEE) ||
                       (code == 8'hFA) || (code == 8'hFE) || (code == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= 3'd0;
      done_d_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      done_d_q   <= done;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (strobe) begin
      case (state_q)
        S_IDLE: begin
          if (code == 8'hE0) state_d = S_E0;
          else if (code == 8'hF0) state_d = S_F0;
          else if (code == 8'hE1) begin
            state_d    = S_PAUSE;
            skip_cnt_d = 3'd7;
          end
        end
        S_E0: begin
          if (code == 8'hF0) state_d = S_E0F0;
          else if (code != 8'hE0) state_d = S_IDLE;
        end
        S_PAUSE: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    emit_code = code;
    perr      = 1'b0;
    if (strobe) begin
      case (state_q)
        S_IDLE: emit = !is_prefix && !is_filtered;
        S_E0: begin
          if (code == 8'hE1) perr = 1'b1;
          else if (code != 8'hF0 && code != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
          end
        end
        S_F0, S_E0F0: begin
          if (is_prefix) perr = 1'b1;
          else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = (state_q == S_E0F0);
          end
        end
        S_PAUSE: begin
          // Pause bytes are swallowed blind; only the count matters.
          if (skip_cnt_q == 3'd1) begin
            emit      = 1'b1;
            emit_code = 8'hE1;
          end
        end
        default: ;
      endcase
    end
  end

  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       caps_lock_q, caps_lock_d, caps_held_q, caps_held_d;
  logic       overflow_q, overflow_d, proto_err_q, proto_err_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [9:0] mem_q [FIFO_DEPTH];
  logic [9:0] mem_d [FIFO_DEPTH];
  logic       empty, full, push, pop;
  logic [9:0] head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && ev_ready;
  assign push  = emit && (!full || pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_lock_d = caps_lock_q;
    caps_held_d = caps_held_q;
    overflow_d  = emit && full && !pop;
    proto_err_d = perr;
    wr_ptr_d    = push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
    mem_d       = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = {emit_brk, emit_ext, emit_code};
    // Modifiers follow the key stream even when the FIFO drops the event.
    if (emit && !emit_ext) begin
      if (emit_code == 8'h12) lshift_d = !emit_brk;
      if (emit_code == 8'h59) rshift_d = !emit_brk;
      if (emit_code == 8'h58) begin
        if (emit_brk) caps_held_d = 1'b0;
        else begin
          if (!caps_held_q) caps_lock_d = !caps_lock_q;
          caps_held_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_lock_q <= 1'b0;
      caps_held_q <= 1'b0;
      overflow_q  <= 1'b0;
      proto_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_lock_q <= caps_lock_d;
      caps_held_q <= caps_held_d;
      overflow_q  <= overflow_d;
      proto_err_q <= proto_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign ev_valid    = !empty;
  assign ev_code     = ev_valid ? head[7:0] : 8'h00;
  assign ev_break    = ev_valid & head[9];
  assign ev_extended = ev_valid & head[8];
  assign shift_held  = lshift_q | rshift_q;
  assign caps_lock   = caps_lock_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_ps2_scancode_processor.sv
// Bench for ps2_scancode_processor: directed test-plan steps then random byte stream vs. a flag/queue reference model.
module tb_ps2_scancode_processor;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] code = 8'h00;
  logic       done = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid, ev_break, ev_extended, shift_held, caps_lock, overflow, proto_err;
  logic [7:0] ev_code;

  int tests = 0;
  int fails = 0;

  // Reference model: pending-prefix flags, pause bytes remaining, event queue, modifier state.
  logic [9:0] q[$];
  bit m_ext, m_brk, m_ls, m_rs, m_caps, m_held;
  int m_pause;

  ps2_scancode_processor #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .code(code), .done(done),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_break(ev_break), .ev_extended(ev_extended), .shift_held(shift_held),
    .caps_lock(caps_lock), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_pre(input logic [7:0] b);
    return (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
  endfunction

  function automatic logic [9:0] head_now();
    return {ev_break, ev_extended, ev_code};
  endfunction

  task automatic model_clear();
    q.delete();
    m_ext = 0; m_brk = 0; m_pause = 0;
    m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev, output bit perr);
    emit = 0; ev = '0; perr = 0;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) begin emit = 1; ev = {2'b00, 8'hE1}; end
    end else if (m_brk) begin
      if (is_pre(b)) perr = 1;
      else begin emit = 1; ev = {1'b1, m_ext, b}; end
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) begin perr = 1; m_ext = 0; end
      else if (b != 8'hE0) begin emit = 1; ev = {2'b01, b}; m_ext = 0; end
    end else begin
      case (b)
        8'hE0: m_ext = 1;
        8'hF0: m_brk = 1;
        8'hE1: m_pause = 7;
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin end
        default: begin emit = 1; ev = {2'b00, b}; end
      endcase
    end
    if (emit && !ev[8]) begin
      if (ev[7:0] == 8'h12) m_ls = !ev[9];
      if (ev[7:0] == 8'h59) m_rs = !ev[9];
      if (ev[7:0] == 8'h58) begin
        if (ev[9]) m_held = 0;
        else begin
          if (!m_held) m_caps = !m_caps;
          m_held = 1;
        end
      end
    end
  endtask

  task automatic check_state(input string tag, input bit exp_ovf, input bit exp_perr);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_perr"}, proto_err, exp_perr);
    check({tag, "_shift"}, shift_held, m_ls | m_rs);
    check({tag, "_caps"}, caps_lock, m_caps);
    check({tag, "_valid"}, ev_valid, q.size() != 0);
    check({tag, "_head"}, head_now(), (q.size() != 0) ? q[0] : 10'h000);
  endtask

  // One byte strobe: done high for one cycle, optional simultaneous pop.
  task automatic send_byte(input logic [7:0] b, input bit pop);
    bit emit, perr, exp_ovf;
    logic [9:0] ev;
    code = b; done = 1'b1; ev_ready = pop;
    if (pop && q.size() > 0) check("pop_head", head_now(), q[0]);
    @(posedge clk); #1;
    model_byte(b, emit, ev, perr);
    exp_ovf = 0;
    if (pop && q.size() > 0) void'(q.pop_front());
    if (emit) begin
      if (q.size() == DEPTH) exp_ovf = 1;
      else q.push_back(ev);
    end
    check_state("byte", exp_ovf, perr);
    done = 1'b0; ev_ready = 1'b0;
    @(posedge clk); #1;
    check("pulse_end_ovf", overflow, 1'b0);
    check("pulse_end_perr", proto_err, 1'b0);
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    while (q.size() > 0) begin
      check("drain_valid", ev_valid, 1'b1);
      check("drain_head", head_now(), q[0]);
      @(posedge clk); #1;
      void'(q.pop_front());
    end
    ev_ready = 1'b0;
    check("drain_empty", ev_valid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    model_clear();
    check("rst_valid", ev_valid, 1'b0);
    check("rst_head", head_now(), 10'h000);
    check("rst_shift", shift_held, 1'b0);
    check("rst_caps", caps_lock, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_perr", proto_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit emit, perr;
    logic [9:0] ev;
    logic [7:0] pause_seq [8];
    logic [7:0] rb;
    model_clear();
    do_reset();

    // Latency: 1C with ev_ready=1 shows exactly one cycle after the done rise, then is popped.
    code = 8'h1C; done = 1'b1; ev_ready = 1'b1;
    check("lat_before", ev_valid, 1'b0);
    @(posedge clk); #1;
    model_byte(8'h1C, emit, ev, perr);
    check("lat_valid", ev_valid, 1'b1);
    check("lat_event", head_now(), 10'h01C);
    @(posedge clk); #1;
    check("lat_popped", ev_valid, 1'b0);
    done = 1'b0; ev_ready = 1'b0;
    @(posedge clk); #1;

    // Up-arrow release.
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h75, 0);
    check("uparrow", head_now(), 10'h375);
    drain();

    // Pause sequence.
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 0);
    check("pause_event", head_now(), 10'h0E1);
    drain();

    // Caps lock with typematic repeat, then shift.
    send_byte(8'h58, 0); check("caps_on", caps_lock, 1'b1);
    send_byte(8'h58, 0); check("caps_repeat", caps_lock, 1'b1);
    send_byte(8'hF0, 0); send_byte(8'h58, 0); check("caps_release", caps_lock, 1'b1);
    send_byte(8'h58, 0); check("caps_off", caps_lock, 1'b0);
    send_byte(8'h12, 0); check("shift_on", shift_held, 1'b1);
    send_byte(8'hF0, 0); send_byte(8'h12, 0); check("shift_off", shift_held, 1'b0);
    drain();

    // Overflow on the 5th make, then in-order drain; then push+pop while full.
    for (int i = 0; i < 5; i++) send_byte(8'h1C + 8'(i), 0);
    drain();
    for (int i = 0; i < 4; i++) send_byte(8'h30 + 8'(i), 0);
    send_byte(8'h3A, 1);
    drain();

    // Illegal F0 E0 then recovery.
    send_byte(8'hF0, 0); send_byte(8'hE0, 0);
    send_byte(8'h1C, 0);
    check("recover", head_now(), 10'h01C);
    drain();

    // done held high for 3 cycles: one event.
    code = 8'h1C; done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_byte(8'h1C, emit, ev, perr);
    if (emit) q.push_back(ev);
    done = 1'b0;
    @(posedge clk); #1;
    check("held_count", ev_valid, 1'b1);
    drain();

    // Reset after E0 drops the prefix.
    send_byte(8'hE0, 0);
    do_reset();
    send_byte(8'h1C, 0);
    check("rst_prefix", head_now(), 10'h01C);
    drain();

    // Random stream.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: rb = 8'hE0;
        1: rb = 8'hF0;
        2: rb = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h1C;
        3: rb = 8'h12;
        4: rb = 8'h59;
        5: rb = 8'h58;
        6: rb = 8'hFA;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      send_byte(rb, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
